// File: rtl/mdclcg_pkg.sv
// Shared types and constants for the coupled two-LCG bit sequencer.
package mdclcg_pkg;
  localparam int WIDTH_C = 64;
  localparam int R1_DEF  = 5;
  localparam int R2_DEF  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_X = 3'd1,
    CALC_Y = 3'd2,
    CMP    = 3'd3,
    EMIT   = 3'd4
  } state_t;
endpackage

// File: rtl/mdclcg_coupled_sequencer_if.sv
// Adder operand/sum bus and packed-word valid/ready stream of the sequencer.
interface mdclcg_coupled_sequencer_if
  import mdclcg_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int OUT_W = 32
);
  logic [WIDTH-1:0] add_in_1;
  logic [WIDTH-1:0] add_in_2;
  logic [WIDTH-1:0] add_in_3;
  logic             add_c_in;
  logic [WIDTH:0]   add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;

  modport master (
    output add_in_1, add_in_2, add_in_3, add_c_in, out_valid, out_word,
    input  add_sum, out_ready
  );

  modport slave (
    input  add_in_1, add_in_2, add_in_3, add_c_in, out_valid, out_word,
    output add_sum, out_ready
  );
endinterface

// File: rtl/mdclcg_word_packer.sv
// Shifts comparison bits into an OUT_W-bit word (first bit ends in the MSB)
// and holds the finished word valid until the consumer accepts it.
module mdclcg_word_packer
  import mdclcg_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             ready,
  output logic [OUT_W-1:0] word,
  output logic             valid,
  output logic             last
);
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [CNT_W-1:0] bit_cnt;

  assign last = shift_en && (bit_cnt == CNT_W'(OUT_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      bit_cnt <= '0;
      valid   <= 1'b0;
    end else if (clr) begin
      word    <= '0;
      bit_cnt <= '0;
      valid   <= 1'b0;
    end else if (shift_en) begin
      word <= {word[OUT_W-2:0], bit_in};
      if (last) begin
        bit_cnt <= '0;
        valid   <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mdclcg_coupled_sequencer.sv
// Two coupled LCGs time-sharing one external 3-operand adder; emits (x > y) bits
// packed into words. Define MDCLCG_DECIM_EN to keep only bits where x[63] = 1.
module mdclcg_coupled_sequencer
  import mdclcg_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int R1    = R1_DEF,
  parameter int R2    = R2_DEF,
  parameter int OUT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      seed_valid,
  input  logic [WIDTH-1:0]          seed_x,
  input  logic [WIDTH-1:0]          seed_y,
  input  logic [WIDTH-1:0]          b1,
  input  logic [WIDTH-1:0]          b2,
  mdclcg_coupled_sequencer_if.master bus,
  output logic                      busy
);
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             seeded;
  logic [WIDTH-1:0] sum;
  logic             sum_carry_unused;
  logic             cmp_bit;
  logic             take_bit;
  logic             shift_en;
  logic             word_last;
  logic             word_valid;
  logic [OUT_W-1:0] word;

  // Only the low WIDTH bits of the sum matter: all state math wraps mod 2^WIDTH.
  assign sum              = bus.add_sum[WIDTH-1:0];
  assign sum_carry_unused = bus.add_sum[WIDTH];
  assign cmp_bit          = (x > y);

`ifdef MDCLCG_DECIM_EN
  assign take_bit = x[WIDTH-1];
`else
  assign take_bit = 1'b1;
`endif

  assign shift_en = (state == CMP) && take_bit && !seed_valid;

  mdclcg_word_packer #(
    .OUT_W (OUT_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (seed_valid),
    .shift_en (shift_en),
    .bit_in   (cmp_bit),
    .ready    (bus.out_ready),
    .word     (word),
    .valid    (word_valid),
    .last     (word_last)
  );

  assign bus.out_word  = word;
  assign bus.out_valid = word_valid;
  assign bus.add_c_in  = 1'b0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      seeded <= 1'b0;
    end else begin
      state <= state_next;
      if (seed_valid) begin
        x      <= seed_x;
        y      <= seed_y;
        seeded <= 1'b1;
      end else if (state == CALC_X) begin
        x <= sum;
      end else if (state == CALC_Y) begin
        y <= sum;
      end
    end
  end

  always_comb begin
    bus.add_in_1 = '0;
    bus.add_in_2 = '0;
    bus.add_in_3 = '0;
    state_next   = state;
    case (state)
      IDLE: begin
        if (run && seeded) state_next = CALC_X;
      end
      CALC_X: begin
        bus.add_in_1 = x << R1;
        bus.add_in_2 = x;
        bus.add_in_3 = b1;
        state_next   = CALC_Y;
      end
      CALC_Y: begin
        bus.add_in_1 = y << R2;
        bus.add_in_2 = y;
        bus.add_in_3 = b2;
        state_next   = CMP;
      end
      CMP: begin
        if (word_last)  state_next = EMIT;
        else if (run)   state_next = CALC_X;
        else            state_next = IDLE;
      end
      EMIT: begin
        if (bus.out_ready) state_next = run ? CALC_X : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A seed load restarts from any state, discarding a pending word.
    if (seed_valid) state_next = run ? CALC_X : IDLE;
  end
endmodule
